tmr_warn_mon: RTL
=================

# tmr_warn_mon

Voter-mismatch monitor sitting directly downstream of a bank of `mvtr` multi-voters. It samples their `warn_o` outputs and counts mismatch events per voter with saturating counters. It also keeps a saturating total, a sticky any-warning flag and the index of the first voter that warned. Counters are read through a one-cycle request/acknowledge port and cleared by a pulse, so slow-control firmware can track TMR upset rates.

## Interface
- `N_VTR`, default 8: number of voter warn inputs monitored (2..32).
- `CNT_W`, default 16: width of each per-voter counter and of the total counter.
- `IDX_W`, default `$clog2(N_VTR)`: index width, derived, not to be overridden.
- `clk_i`  in  1  single system clock; all logic is on its rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `warn_i`  in  N_VTR  `warn_o` of each voter; combinational, asynchronous to nothing (same clock domain).
- `clr_i`  in  1  one-cycle pulse: clear all counters, sticky flag and first-index latch.
- `rd_req_i`  in  1  read request; one-cycle pulse.
- `rd_sel_i`  in  IDX_W  voter index to read; `N_VTR` and above selects the total counter only if `IDX_W` allows, otherwise the read returns 0.
- `rd_ack_o`  out  1  one-cycle acknowledge; `rd_data_o` is valid while it is high.
- `rd_data_o`  out  CNT_W  counter value captured at request.
- `any_warn_o`  out  1  sticky: at least one event since the last reset or clear.
- `first_vld_o`  out  1  `first_idx_o` holds a valid index.
- `first_idx_o`  out  IDX_W  index of the first voter to raise an event.
- `total_o`  out  CNT_W  saturating total of all events, live.

## Operation
- Input stage: `warn_i` is registered into `warn_q`. `warn_q` is registered into `warn_qq`.
- An event is declared per voter when `warn_q & ~warn_qq` is high.
- A persistent mismatch counts exactly once. It counts again only after the warning drops and rises again.
- Per-voter counters: +1 per event. They saturate at 2^CNT_W−1 and hold that value. They never wrap.
- Total counter: adds the popcount of the events in each cycle. It saturates at 2^CNT_W−1, and any add that would pass full clamps to full.
- First-index latch: while `first_vld_o`=0, any event loads the lowest event index and sets `first_vld_o`. The latch is frozen until clear.
- `any_warn_o` is set on any event and held.
- `clr_i` has priority over events in the same cycle. Those events are dropped. `warn_q` and `warn_qq` are not cleared, so a warning still high after the clear does not re-count.
- Read FSM, states IDLE and ACK:
  - IDLE with `rd_req_i`=1: capture the selected counter (pre-update value of that cycle) into the data register, then go to ACK.
  - ACK: `rd_ack_o`=1 for exactly one cycle, then return to IDLE.
  - A `rd_req_i` arriving while in ACK is ignored.
- Read and clear in the same cycle: the read returns the pre-clear value.
- Reset: all counters = 0, `any_warn_o`=0, `first_vld_o`=0, `first_idx_o`=0, `rd_ack_o`=0, `rd_data_o`=0, FSM = IDLE, `warn_q`=`warn_qq`=0.
- A warning already high when reset is released counts once.
- Reset asserted mid-read aborts the ACK. `rd_ack_o` is 0 on the cycle after the reset edge.

## Timing
- Call the edge where `warn_i` is first sampled high edge k.
- At edge k+1 the counter, total, sticky flag and first latch update. They are visible after that edge, i.e. 2 cycles from the combinational `warn_i` change.
- Read: request sampled at edge r, `rd_ack_o`/`rd_data_o` valid between edge r+1 and edge r+2.
- Minimum spacing between accepted requests is 2 cycles.
- `clr_i` sampled at edge c: all state is zero after edge c.
- `total_o` and the flags are registered outputs with no combinational path from inputs.

## Structure
- Package `tmr_mon_pkg` contains:
  - the read-FSM state enum (`RD_IDLE`, `RD_ACK`);
  - the default `CNT_W`;
  - a `sat_max` constant function.
- Sub-module `tmr_sat_cnt` holds a parameterised saturating counter with synchronous clear and increment amount. It is instantiated N_VTR times for the per-voter counters (increment width 1) and once for the total (increment width `$clog2(N_VTR+1)`).
- The popcount and the lowest-index priority encoder are local functions in the top level.

## Test plan
- Single event: reset, then raise `warn_i[3]` for 5 cycles and drop it. Read voter 3 → 1, `total_o`=1, `first_idx_o`=3, `first_vld_o`=1, `any_warn_o`=1.
- Simultaneous: `warn_i`=8'b0101_0010 rising in one cycle → `total_o`=3, `first_idx_o`=1. Counters 1, 4 and 6 read 1, all others read 0.
- Saturation: with CNT_W=4, pulse `warn_i[0]` 20 times, each pulse 1 cycle high and 1 cycle low. Voter 0 reads 15, and `total_o` reaches 15 and stays there.
- Clear priority: assert `clr_i` in the same cycle as a new event on voter 2, with `rd_req_i` selecting voter 2 (count previously 4). Read returns 4, then a fresh read returns 0, `any_warn_o`=0 and `first_vld_o`=0. `warn_i[2]`, still high, does not re-count.
- Handshake: `rd_req_i` on two consecutive cycles → exactly one `rd_ack_o` pulse, carrying the first selection.
- Reset mid-read: assert `rst_i` on the cycle the FSM is in ACK → `rd_ack_o`=0 the next cycle and all outputs read 0. A held `warn_i[5]` then counts 1 after release.

Source files
------------

// File: rtl/tmr_mon_pkg.sv
// Shared types and helpers for the TMR voter-mismatch monitor.
package tmr_mon_pkg;

    // Read handshake states: waiting for a request, or presenting data.
    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_ACK  = 1'b1
    } rd_state_t;

    // Default counter width for per-voter and total counters.
    localparam int DEF_CNT_W = 16;

    // All-ones value of a w-bit counter.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/tmr_sat_cnt.sv
// Saturating up-counter with synchronous clear and a multi-bit increment.
// An add that would pass the all-ones value clamps to all-ones.
module tmr_sat_cnt
    import tmr_mon_pkg::*;
#(
    parameter int W     = DEF_CNT_W,
    parameter int INC_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic [INC_W-1:0] inc_i,
    output logic [W-1:0]     cnt_o
);

    localparam logic [W-1:0] MAX_C = W'(sat_max(W));

    logic [W-1:0]       cnt_r;
    logic [W-1:0]       nxt_s;
    logic [W+INC_W-1:0] sum_s;

    // Widened add so overflow is visible, then clamp to full scale.
    always_comb begin
        sum_s = {{INC_W{1'b0}}, cnt_r} + {{W{1'b0}}, inc_i};
        nxt_s = cnt_r;
        if (sum_s > {{INC_W{1'b0}}, MAX_C}) begin
            nxt_s = MAX_C;
        end else begin
            nxt_s = sum_s[W-1:0];
        end
    end

    // Counter register; clear wins over any increment in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= {W{1'b0}};
        end else if (clr_i) begin
            cnt_r <= {W{1'b0}};
        end else begin
            cnt_r <= nxt_s;
        end
    end

    assign cnt_o = cnt_r;

endmodule

// File: rtl/tmr_warn_mon.sv
// Voter-mismatch monitor: edge-detects each voter warn line, keeps
// saturating per-voter and total event counts, a sticky flag and the index
// of the first voter to warn. Counters are read via a one-cycle req/ack.
module tmr_warn_mon
    import tmr_mon_pkg::*;
#(
    parameter int N_VTR = 8,
    parameter int CNT_W = DEF_CNT_W,
    parameter int IDX_W = $clog2(N_VTR)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_VTR-1:0] warn_i,
    input  logic             clr_i,
    input  logic             rd_req_i,
    input  logic [IDX_W-1:0] rd_sel_i,
    output logic             rd_ack_o,
    output logic [CNT_W-1:0] rd_data_o,
    output logic             any_warn_o,
    output logic             first_vld_o,
    output logic [IDX_W-1:0] first_idx_o,
    output logic [CNT_W-1:0] total_o
);

    localparam int               INC_W   = $clog2(N_VTR + 1);
    localparam logic [IDX_W:0]   N_VTR_W = (IDX_W + 1)'(N_VTR);

    // Number of set bits in an event vector.
    function automatic logic [INC_W-1:0] popcount(input logic [N_VTR-1:0] v);
        logic [INC_W-1:0] c;
        c = {INC_W{1'b0}};
        for (int i = 0; i < N_VTR; i++) begin
            c = c + {{(INC_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Index of the lowest set bit (0 when the vector is empty).
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_VTR-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = N_VTR - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    logic [N_VTR-1:0] warn_q_r;
    logic [N_VTR-1:0] warn_qq_r;
    logic [N_VTR-1:0] evt_s;
    logic [CNT_W-1:0] cnt_s [N_VTR];
    logic [CNT_W-1:0] total_s;
    logic [CNT_W-1:0] sel_val_s;
    logic [CNT_W-1:0] rd_data_r;
    logic             any_warn_r;
    logic             first_vld_r;
    logic [IDX_W-1:0] first_idx_r;
    logic             capture_s;
    rd_state_t        state_r;
    rd_state_t        state_nxt_s;

    // Two-stage sampling of the warn lines; not touched by clear so a
    // warning still high afterwards is not counted a second time.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            warn_q_r  <= {N_VTR{1'b0}};
            warn_qq_r <= {N_VTR{1'b0}};
        end else begin
            warn_q_r  <= warn_i;
            warn_qq_r <= warn_q_r;
        end
    end

    // Rising-edge events; a clear in the same cycle drops them.
    always_comb begin
        evt_s = {N_VTR{1'b0}};
        if (clr_i) begin
            evt_s = {N_VTR{1'b0}};
        end else begin
            evt_s = warn_q_r & ~warn_qq_r;
        end
    end

    for (genvar g = 0; g < N_VTR; g++) begin : g_vtr_cnt
        tmr_sat_cnt #(.W(CNT_W), .INC_W(1)) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (clr_i),
            .inc_i (evt_s[g]),
            .cnt_o (cnt_s[g])
        );
    end

    tmr_sat_cnt #(.W(CNT_W), .INC_W(INC_W)) u_total (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr_i),
        .inc_i (popcount(evt_s)),
        .cnt_o (total_s)
    );

    // Sticky flag and first-warner latch; the latch freezes once valid.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            any_warn_r  <= 1'b0;
            first_vld_r <= 1'b0;
            first_idx_r <= {IDX_W{1'b0}};
        end else begin
            if (|evt_s) begin
                any_warn_r <= 1'b1;
            end
            if (!first_vld_r && (|evt_s)) begin
                first_vld_r <= 1'b1;
                first_idx_r <= lowest_idx(evt_s);
            end
        end
    end

    // Read mux: voter counters, then the total for indices past the last voter.
    always_comb begin
        sel_val_s = {CNT_W{1'b0}};
        if ({1'b0, rd_sel_i} < N_VTR_W) begin
            sel_val_s = cnt_s[rd_sel_i];
        end else begin
            sel_val_s = total_s;
        end
    end

    // Read FSM next state; requests seen while acknowledging are ignored.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        case (state_r)
            RD_IDLE: begin
                if (rd_req_i) begin
                    state_nxt_s = RD_ACK;
                    capture_s   = 1'b1;
                end else begin
                    state_nxt_s = RD_IDLE;
                end
            end
            RD_ACK:  state_nxt_s = RD_IDLE;
            default: state_nxt_s = RD_IDLE;
        endcase
    end

    // Read FSM state and data capture (pre-update counter value).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= RD_IDLE;
            rd_data_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (capture_s) begin
                rd_data_r <= sel_val_s;
            end
        end
    end

    assign rd_ack_o    = (state_r == RD_ACK);
    assign rd_data_o   = rd_data_r;
    assign any_warn_o  = any_warn_r;
    assign first_vld_o = first_vld_r;
    assign first_idx_o = first_idx_r;
    assign total_o     = total_s;

endmodule
